// File: rtl/ahb_master_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_master_ctrl_if
// Brief    : Instruction handoff and AHB-Lite master bus bundle for ahb_master_ctrl
// Revision : 1.0 - initial release
// ============================================================================
interface ahb_master_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              START;
    logic [31:0]       INSTR;
    logic              stall_flag;
    logic              HREADY;
    logic              HRESP;
    logic [DATA_W-1:0] HRDATA;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic [2:0]        HBURST;
    logic [2:0]        HSIZE;
    logic              HWRITE;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] RDATA_OUT;
    logic              RDATA_VALID;
    logic              ERROR;

    // The controller itself
    modport master (
        input  START, INSTR, HREADY, HRESP, HRDATA,
        output stall_flag, HADDR, HTRANS, HBURST, HSIZE, HWRITE, HWDATA,
               RDATA_OUT, RDATA_VALID, ERROR
    );

    // Upstream fetch stage plus the addressed AHB slave
    modport slave (
        output START, INSTR, HREADY, HRESP, HRDATA,
        input  stall_flag, HADDR, HTRANS, HBURST, HSIZE, HWRITE, HWDATA,
               RDATA_OUT, RDATA_VALID, ERROR
    );
endinterface
`default_nettype wire

// File: rtl/ahb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ahb_master_ctrl
// Brief    : Executes one encoded AHB-Lite transfer (SINGLE/INCR/WRAP) per START
// Revision : 1.0 - initial release
// ============================================================================
module ahb_master_ctrl #(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input wire                 HCLK,
    input wire                 HRESETn,
    ahb_master_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_BURST = 3'd2,
        S_LAST  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam int         C_MAX_SIZE    = $clog2(DATA_W / 8);
    localparam logic [1:0] C_HTRANS_IDLE = 2'b00;
    localparam logic [1:0] C_HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] C_HTRANS_SEQ  = 2'b11;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_inc;
    logic [ADDR_W-1:0]   r_mask;
    logic [7:0]          r_beats;
    logic [7:0]          r_abeat;
    logic [15:0]         r_offset;
    logic [2:0]          r_burst;
    logic [2:0]          r_size;
    logic                r_write;
    logic [DATA_W-1:0]   r_hwdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rvalid;
    logic                r_error;

    logic [2:0]          w_dec_burst;
    logic [2:0]          w_dec_size;
    logic [7:0]          w_dec_count;
    logic                w_dec_wrap;
    logic                w_illegal;
    logic [7:0]          w_dec_beats;
    logic [ADDR_W-1:0]   w_dec_inc;
    logic [ADDR_W-1:0]   w_dec_start;
    logic [ADDR_W-1:0]   w_dec_window;
    logic [ADDR_W-1:0]   w_dec_mask;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                w_dphase;
    logic                w_bus_err;
    logic                w_accept;
    logic                w_load;

    // ------------------------------------------------------------------
    // Instruction decode (only meaningful while IDLE and START is high)
    // ------------------------------------------------------------------
    assign w_dec_burst = bus.INSTR[30:28];
    assign w_dec_size  = bus.INSTR[26:24];
    assign w_dec_count = bus.INSTR[23:16];
    assign w_dec_wrap  = (w_dec_burst == 3'b010) || (w_dec_burst == 3'b100) ||
                         (w_dec_burst == 3'b110);
    assign w_illegal   = (w_dec_size > 3'(C_MAX_SIZE)) || bus.INSTR[27] ||
                         (bus.INSTR == 32'hFFFF_FFFF);

    always_comb begin
        w_dec_beats = 8'd16;
        case (w_dec_burst)
            3'b000:         w_dec_beats = 8'd1;
            3'b001:         w_dec_beats = (w_dec_count == 8'd0) ? 8'd1 : w_dec_count;
            3'b010, 3'b011: w_dec_beats = 8'd4;
            3'b100, 3'b101: w_dec_beats = 8'd8;
            default:        w_dec_beats = 8'd16;
        endcase
    end

    assign w_dec_inc    = ADDR_W'(1) << w_dec_size;
    assign w_dec_start  = (BASE_ADDR + ADDR_W'(bus.INSTR[15:0])) & ~(w_dec_inc - ADDR_W'(1));
    assign w_dec_window = ADDR_W'(w_dec_beats) << w_dec_size;
    // An all-ones mask turns the wrapping address step into a plain linear one
    assign w_dec_mask   = w_dec_wrap ? (w_dec_window - ADDR_W'(1)) : '1;

    assign w_addr_nxt   = (r_addr & ~r_mask) | ((r_addr + r_inc) & r_mask);

    // A data phase is outstanding in BURST (previous beat) and LAST (final beat)
    assign w_dphase  = (r_state == S_BURST) || (r_state == S_LAST);
    assign w_bus_err = w_dphase && bus.HRESP && !bus.HREADY;
    assign w_load    = (r_state == S_IDLE) && bus.START && !w_illegal;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.HREADY) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (r_beats == 8'd1) ? S_LAST : S_BURST;
                end
            end
            S_BURST: begin
                if (w_bus_err) begin
                    w_state_nxt = S_ERR;
                end else if (bus.HREADY) begin
                    w_accept = 1'b1;
                    if (r_abeat == (r_beats - 8'd1)) begin
                        w_state_nxt = S_LAST;
                    end
                end
            end
            S_LAST: begin
                if (w_bus_err) begin
                    w_state_nxt = S_ERR;
                end else if (bus.HREADY) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr   <= '0;
            r_inc    <= '0;
            r_mask   <= '0;
            r_beats  <= 8'd0;
            r_abeat  <= 8'd0;
            r_offset <= 16'd0;
            r_burst  <= 3'd0;
            r_size   <= 3'd0;
            r_write  <= 1'b0;
            r_hwdata <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_error  <= 1'b0;

            if ((r_state == S_IDLE) && bus.START && w_illegal) begin
                r_error <= 1'b1;
            end

            if (w_load) begin
                r_addr   <= w_dec_start;
                r_inc    <= w_dec_inc;
                r_mask   <= w_dec_mask;
                r_beats  <= w_dec_beats;
                r_abeat  <= 8'd0;
                r_offset <= bus.INSTR[15:0];
                r_burst  <= w_dec_burst;
                r_size   <= w_dec_size;
                r_write  <= bus.INSTR[31];
            end

            // Write data for the beat whose address was just accepted
            if (w_accept) begin
                r_hwdata <= DATA_W'({r_offset, 8'h00, r_abeat});
                r_addr   <= w_addr_nxt;
                r_abeat  <= r_abeat + 8'd1;
            end

            if (w_bus_err) begin
                r_error <= 1'b1;
            end

            if (w_dphase && bus.HREADY && !bus.HRESP && !r_write) begin
                r_rdata  <= bus.HRDATA;
                r_rvalid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.HTRANS      = (r_state == S_ADDR)  ? C_HTRANS_NSEQ :
                             (r_state == S_BURST) ? C_HTRANS_SEQ  : C_HTRANS_IDLE;
    assign bus.HADDR       = r_addr;
    assign bus.HBURST      = r_burst;
    assign bus.HSIZE       = r_size;
    assign bus.HWRITE      = r_write;
    assign bus.HWDATA      = r_hwdata;
    assign bus.RDATA_OUT   = r_rdata;
    assign bus.RDATA_VALID = r_rvalid;
    assign bus.ERROR       = r_error;
    // Forced low during reset so every output reads 0 regardless of START
    assign bus.stall_flag  = HRESETn && ((r_state != S_IDLE) || bus.START);

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_master_ctrl
// Brief    : Directed plus randomized self-checking bench for ahb_master_ctrl
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_master_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ahb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference rules for a transfer instruction
    function automatic bit ref_illegal(input logic [31:0] ins);
        return (ins[26:24] > 3'd2) || ins[27] || (ins == 32'hFFFF_FFFF);
    endfunction

    function automatic int ref_beats(input logic [31:0] ins);
        case (ins[30:28])
            3'b000:         return 1;
            3'b001:         return (ins[23:16] == 8'd0) ? 1 : int'(ins[23:16]);
            3'b010, 3'b011: return 4;
            3'b100, 3'b101: return 8;
            default:        return 16;
        endcase
    endfunction

    function automatic logic [31:0] ref_addr(input logic [31:0] ins, input int k);
        int unsigned inc;
        int unsigned start;
        int unsigned win;
        inc   = 32'd1 << ins[26:24];
        start = ((BASE + 32'(ins[15:0])) / inc) * inc;
        if (ins[30:28] == 3'b010 || ins[30:28] == 3'b100 || ins[30:28] == 3'b110) begin
            win = ref_beats(ins) * inc;
            return (start / win) * win + ((start % win) + k * inc) % win;
        end
        return start + k * inc;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_haddr"},  bus.HADDR, 32'h0);
        chk({tag, "_htrans"}, bus.HTRANS, 32'h0);
        chk({tag, "_hburst"}, bus.HBURST, 32'h0);
        chk({tag, "_hsize"},  bus.HSIZE, 32'h0);
        chk({tag, "_hwrite"}, bus.HWRITE, 32'h0);
        chk({tag, "_hwdata"}, bus.HWDATA, 32'h0);
        chk({tag, "_stall"},  bus.stall_flag, 32'h0);
        chk({tag, "_rdata"},  bus.RDATA_OUT, 32'h0);
        chk({tag, "_rvalid"}, bus.RDATA_VALID, 32'h0);
        chk({tag, "_error"},  bus.ERROR, 32'h0);
    endtask

    // Issues one instruction and plays the AHB slave, checking every cycle.
    // Entered and left just after a falling edge with the controller idle.
    task automatic do_xfer(input logic [31:0] ins, input int err_beat, input int wait_beat,
                           input int wait_cnt, input int wait_pct, input int abort_after);
        int          n;
        int          abeat;
        int          dpend;
        int          waits_left;
        int          cyc;
        bit          wr;
        bit          active;
        bit          err_pend;
        bit          exp_rv;
        logic [31:0] exp_rd;
        logic [1:0]  exp_tr;

        bus.START = 1'b1;
        bus.INSTR = ins;
        #1;
        chk("stall_on_start", bus.stall_flag, 1);
        chk("idle_before_nonseq", bus.HTRANS, 2'b00);
        @(negedge HCLK);
        bus.START = 1'b0;
        bus.INSTR = $urandom;
        #1;

        if (ref_illegal(ins)) begin
            chk("illegal_error_pulse", bus.ERROR, 1);
            chk("illegal_htrans", bus.HTRANS, 2'b00);
            chk("illegal_stall", bus.stall_flag, 0);
            @(negedge HCLK);
            #1;
            chk("illegal_error_once", bus.ERROR, 0);
            chk("illegal_htrans2", bus.HTRANS, 2'b00);
            return;
        end

        n          = ref_beats(ins);
        wr         = ins[31];
        abeat      = 0;
        dpend      = -1;
        waits_left = wait_cnt;
        err_pend   = 1'b0;
        exp_rv     = 1'b0;
        exp_rd     = '0;

        for (cyc = 0; cyc < 2000; cyc++) begin
            if (cyc == abort_after) return;
            chk("rdata_valid", bus.RDATA_VALID, exp_rv);
            if (exp_rv) chk("rdata_out", bus.RDATA_OUT, exp_rd);

            if (err_pend) begin
                chk("err_htrans_idle", bus.HTRANS, 2'b00);
                chk("err_pulse", bus.ERROR, 1);
                chk("err_stall", bus.stall_flag, 1);
                bus.HREADY = 1'b1;
                bus.HRESP  = 1'b1;
                @(negedge HCLK);
                #1;
                bus.HRESP = 1'b0;
                chk("err_done_error", bus.ERROR, 0);
                chk("err_done_stall", bus.stall_flag, 0);
                chk("err_done_rvalid", bus.RDATA_VALID, 0);
                chk("err_done_htrans", bus.HTRANS, 2'b00);
                return;
            end

            if (abeat == n && dpend < 0) begin
                chk("done_stall", bus.stall_flag, 0);
                chk("done_htrans", bus.HTRANS, 2'b00);
                chk("done_error", bus.ERROR, 0);
                return;
            end

            active = (abeat < n);
            exp_tr = !active ? 2'b00 : (abeat == 0) ? 2'b10 : 2'b11;
            chk("htrans", bus.HTRANS, exp_tr);
            chk("stall_busy", bus.stall_flag, 1);
            chk("error_quiet", bus.ERROR, 0);
            if (active) begin
                chk("haddr", bus.HADDR, ref_addr(ins, abeat));
                chk("hburst", bus.HBURST, ins[30:28]);
                chk("hsize", bus.HSIZE, ins[26:24]);
                chk("hwrite", bus.HWRITE, ins[31]);
            end
            if (dpend >= 0 && wr) chk("hwdata", bus.HWDATA, {ins[15:0], 8'h00, 8'(dpend)});

            bus.HRDATA = $urandom;
            bus.HRESP  = 1'b0;
            bus.HREADY = 1'b1;
            if (dpend >= 0 && dpend == err_beat) begin
                bus.HREADY = 1'b0;
                bus.HRESP  = 1'b1;
                err_pend   = 1'b1;
            end else if (dpend >= 0 && dpend == wait_beat && waits_left > 0) begin
                bus.HREADY = 1'b0;
                waits_left--;
            end else if (dpend >= 0 && $urandom_range(99) < wait_pct) begin
                bus.HREADY = 1'b0;
            end

            exp_rv = bus.HREADY && (dpend >= 0) && !wr;
            exp_rd = bus.HRDATA;
            if (bus.HREADY) begin
                dpend = active ? abeat : -1;
                if (active) abeat++;
            end
            @(negedge HCLK);
            #1;
        end
        chk("xfer_within_budget", cyc < 2000, 1);
    endtask

    initial begin
        logic [31:0] ins;
        int          eb;

        bus.START  = 1'b0;
        bus.INSTR  = '0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = '0;

        repeat (3) @(negedge HCLK);
        #1;
        chk_all_zero("reset");
        HRESETn = 1'b1;
        @(negedge HCLK);
        #1;

        // Directed cases
        do_xfer(32'h8200_0010, -1, -1, 0, 0, -1);
        do_xfer(32'h1100_0020, -1,  2, 3, 0, -1);
        do_xfer(32'h2200_0038, -1, -1, 0, 0, -1);
        do_xfer(32'hA200_0038, -1, -1, 0, 0, -1);
        do_xfer(32'h1008_0000,  3, -1, 0, 0, -1);
        do_xfer(32'hFFFF_FFFF, -1, -1, 0, 0, -1);
        do_xfer(32'h0300_0000, -1, -1, 0, 0, -1);
        do_xfer(32'h0800_0010, -1, -1, 0, 0, -1);
        do_xfer(32'h1000_0045, -1, -1, 0, 0, -1);
        do_xfer(32'h4100_0036, -1,  7, 2, 0, -1);
        do_xfer(32'h6200_0040, -1, -1, 0, 0, -1);
        do_xfer(32'h0200_0004,  0, -1, 0, 0, -1);

        // Reset in the middle of an INCR16 burst
        do_xfer(32'hF200_0104, -1, -1, 0, 0, 6);
        #2;
        HRESETn    = 1'b0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        #1;
        do_xfer(32'h0100_0022, -1, -1, 0, 0, -1);

        // Randomized transfers
        for (int t = 0; t < 60; t++) begin
            ins         = $urandom;
            ins[27]     = ($urandom_range(15) == 0);
            if ($urandom_range(9) != 0) ins[26:24] = 3'($urandom_range(2));
            ins[23:16]  = 8'($urandom_range(12));
            eb          = -1;
            if (!ref_illegal(ins) && $urandom_range(4) == 0)
                eb = $urandom_range(ref_beats(ins) - 1);
            do_xfer(ins, eb, -1, 0, 30, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
